// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module  : piso_pkg
// Purpose : Shared types and helpers for the piso_ser parallel-to-serial
//           converter: FSM state encoding, default word width and the
//           even-parity helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package piso_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Even parity: the bit that makes the total count of ones even.
  // Callers zero-extend narrower words, which leaves the result unchanged.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_buf.sv
`default_nettype none
// ============================================================================
// Module  : piso_buf
// Purpose : One-entry holding buffer between the upstream valid/ready port
//           and the serializer's shift register.
// Ports   : clk, reset_n      - clock, asynchronous active-low reset
//           in_data/in_valid  - upstream word and its qualifier
//           in_ready          - buffer can take a word this cycle
//           take              - serializer consumes the stored word
//           data/full         - stored word and occupancy flag
// Revision: 1.0 - initial release
// ============================================================================
module piso_buf
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             take,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  logic load;

  // Gated by reset_n so ready reads 0 while reset is held and rises in the
  // first cycle after release.
  assign in_ready = reset_n & ~full;
  assign load     = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
      full <= 1'b0;
    end else begin
      if (load) begin
        data <= in_data;
      end
      // A load wins over a simultaneous take: the new word stays resident
      // while the old one has already moved into the shift register.
      if (load) begin
        full <= 1'b1;
      end else if (take) begin
        full <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/piso_ser.sv
`default_nettype none
// ============================================================================
// Module  : piso_ser
// Purpose : Parallel-in serial-out converter, MSB first, with a one-entry
//           holding buffer allowing back-to-back words with no gap.
//           Optional feature macro PISO_PARITY_EN appends one even-parity
//           bit after every word.
// Ports   : clk, reset_n            - clock, asynchronous active-low reset
//           par_data/par_valid/par_ready - upstream parallel handshake
//           ser_stall               - downstream hold request
//           ser_data/ser_en         - serial bit and its enable
//           word_done               - pulse with the final bit of a word
//           busy                    - FSM active or buffer occupied
// Revision: 1.0 - initial release
// ============================================================================
module piso_ser
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] par_data,
  input  logic             par_valid,
  output logic             par_ready,
  input  logic             ser_stall,
  output logic             ser_data,
  output logic             ser_en,
  output logic             word_done,
  output logic             busy
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] sr, sr_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             take;
  logic             finish;
  logic [WIDTH-1:0] buf_data;
  logic             buf_full;

  piso_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (par_data),
    .in_valid (par_valid),
    .in_ready (par_ready),
    .take     (take),
    .data     (buf_data),
    .full     (buf_full)
  );

`ifdef PISO_PARITY_EN
  // Parity of the word currently in the shift register, captured on load
  // because the shift register no longer holds the word by the parity cycle.
  logic parity_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else if (take) begin
      parity_q <= even_parity(32'(buf_data));
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      sr    <= sr_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    sr_next    = sr;
    cnt_next   = cnt;
    take       = 1'b0;
    finish     = 1'b0;
    ser_en     = 1'b0;
    ser_data   = 1'b0;
    word_done  = 1'b0;

    case (state)
      IDLE: begin
        // finish path below reuses the same reload; here only a full buffer
        // starts a word.
        if (buf_full) begin
          take       = 1'b1;
          sr_next    = buf_data;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        ser_en   = ~ser_stall;
        ser_data = sr[WIDTH-1];
        if (!ser_stall) begin
          if (cnt == LAST) begin
`ifdef PISO_PARITY_EN
            state_next = PARITY;
`else
            word_done  = 1'b1;
            finish     = 1'b1;
`endif
          end else begin
            sr_next  = {sr[WIDTH-2:0], 1'b0};
            cnt_next = cnt + 1'b1;
          end
        end
      end

`ifdef PISO_PARITY_EN
      PARITY: begin
        ser_en   = ~ser_stall;
        ser_data = parity_q;
        if (!ser_stall) begin
          word_done = 1'b1;
          finish    = 1'b1;
        end
      end
`endif

      default: begin
        state_next = IDLE;
      end
    endcase

    // End of word: reload straight from the buffer for zero-gap streaming,
    // otherwise park in IDLE with a cleared datapath.
    if (finish) begin
      cnt_next = '0;
      if (buf_full) begin
        take       = 1'b1;
        sr_next    = buf_data;
        state_next = SHIFT;
      end else begin
        sr_next    = '0;
        state_next = IDLE;
      end
    end
  end

  assign busy = (state != IDLE) | buf_full;

endmodule
`default_nettype wire
